// File: rtl/tft_spi_sink_pkg.sv
// tft_spi_sink_pkg: shared command codes, decoder states and widths for the TFT SPI sink.
package tft_spi_sink_pkg;
  localparam int COORD_W = 9;
  localparam int PIXEL_W = 16;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR_HI,
    ST_RAMWR_LO
  } dec_state_t;
endpackage

// File: rtl/tft_spi_byte_rx.sv
// tft_spi_byte_rx: synchronises the snooped SPI pins and assembles MSB-first bytes,
// discarding a partial byte after IDLE_TIMEOUT clk cycles without a tft_clk rise.
module tft_spi_byte_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_clk,
  input  logic       tft_mosi,
  input  logic       tft_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_error
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [SYNC_STAGES-1:0] sc, sm, sd;
  logic clk_q, edge_det, timeout;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [IW-1:0] idle;
  assign edge_det = sc[SYNC_STAGES-1] & ~clk_q;
  // Fires on the cycle the idle counter would reach the limit, only with a byte in flight.
  assign timeout = !edge_det && idle == IW'(IDLE_TIMEOUT - 1) && bit_cnt != 3'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
      sm <= '0;
      sd <= '0;
      clk_q <= 1'b0;
      bit_cnt <= 3'd0;
      shreg <= 7'd0;
      idle <= '0;
      byte_valid <= 1'b0;
      byte_data <= 8'd0;
      byte_dc <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sc <= {sc[SYNC_STAGES-2:0], tft_clk};
      sm <= {sm[SYNC_STAGES-2:0], tft_mosi};
      sd <= {sd[SYNC_STAGES-2:0], tft_dc};
      clk_q <= sc[SYNC_STAGES-1];
      byte_valid <= edge_det && bit_cnt == 3'd7;
      frame_error <= timeout;
      if (edge_det) begin
        shreg <= {shreg[5:0], sm[SYNC_STAGES-1]};
        bit_cnt <= bit_cnt + 3'd1;
        idle <= '0;
        if (bit_cnt == 3'd7) begin
          byte_data <= {shreg, sm[SYNC_STAGES-1]};
          byte_dc <= sd[SYNC_STAGES-1];
        end
      end else begin
        if (idle != IW'(IDLE_TIMEOUT)) idle <= idle + 1'b1;
        if (timeout) bit_cnt <= 3'd0;
      end
    end
  end
endmodule

// File: rtl/tft_spi_sink.sv
// tft_spi_sink: passive ILI9341 SPI snooper decoding CASET/PASET/RAMWR into
// per-pixel writes with absolute coordinates.
module tft_spi_sink
  import tft_spi_sink_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64,
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tft_clk,
  input  logic               tft_mosi,
  input  logic               tft_dc,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [PIXEL_W-1:0] pixel_color,
  output logic               frame_error
);
  dec_state_t state, nstate;
  logic is_cmd, is_dat;
  logic [1:0] idx;
  logic [COORD_W-1:0] xs, xe, ys, ye, x, y, ts;
  logic te;
  logic [7:0] hi, cmd_q;
  tft_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .IDLE_TIMEOUT(IDLE_TIMEOUT)) u_rx (
    .clk(clk), .rst(rst), .tft_clk(tft_clk), .tft_mosi(tft_mosi), .tft_dc(tft_dc),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .frame_error(frame_error)
  );
  assign is_cmd = byte_valid & ~byte_dc;
  assign is_dat = byte_valid & byte_dc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state;
    if (is_cmd)
      nstate = byte_data == CMD_CASET ? ST_CASET :
               byte_data == CMD_PASET ? ST_PASET :
               byte_data == CMD_RAMWR ? ST_RAMWR_HI : ST_IDLE;
    else if (is_dat)
      nstate = (state == ST_CASET || state == ST_PASET) ? (idx == 2'd3 ? ST_IDLE : state) :
               state == ST_RAMWR_HI ? ST_RAMWR_LO :
               state == ST_RAMWR_LO ? ST_RAMWR_HI : state;
  end
  always_comb begin
    cmd_valid = is_cmd;
    cmd_code = is_cmd ? byte_data : cmd_q;
    pixel_valid = is_dat && state == ST_RAMWR_LO;
    pixel_x = x;
    pixel_y = y;
    pixel_color = {hi, byte_data};
  end
  // Window values are 16 bits on the wire; only bit 8 of the high byte survives truncation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      ts <= '0;
      te <= 1'b0;
      xs <= '0;
      xe <= COORD_W'(WIDTH - 1);
      ys <= '0;
      ye <= COORD_W'(HEIGHT - 1);
      x <= '0;
      y <= '0;
      hi <= 8'd0;
      cmd_q <= 8'd0;
    end else if (is_cmd) begin
      idx <= 2'd0;
      cmd_q <= byte_data;
      if (byte_data == CMD_RAMWR) begin
        x <= xs;
        y <= ys;
      end
    end else if (is_dat) begin
      if (state == ST_CASET || state == ST_PASET) begin
        idx <= idx + 2'd1;
        if (idx == 2'd0) ts[8] <= byte_data[0];
        if (idx == 2'd1) ts[7:0] <= byte_data;
        if (idx == 2'd2) te <= byte_data[0];
        if (idx == 2'd3 && state == ST_CASET) begin
          xs <= ts;
          xe <= {te, byte_data};
        end
        if (idx == 2'd3 && state == ST_PASET) begin
          ys <= ts;
          ye <= {te, byte_data};
        end
      end
      if (state == ST_RAMWR_HI) hi <= byte_data;
      if (state == ST_RAMWR_LO) begin
        if (x == xe || xs > xe) begin
          x <= xs;
          y <= (y == ye || ys > ye) ? ys : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tft_spi_sink.sv
// tb_tft_spi_sink: directed self-checking bench driving SPI bytes into tft_spi_sink.
module tb_tft_spi_sink;
  logic clk = 0, rst = 1, tft_clk = 0, tft_mosi = 0, tft_dc = 0;
  logic byte_valid, byte_dc, cmd_valid, pixel_valid, frame_error;
  logic [7:0] byte_data, cmd_code;
  logic [8:0] pixel_x, pixel_y;
  logic [15:0] pixel_color;
  int errors = 0, checks = 0, fe_cnt = 0;
  typedef struct {logic [8:0] x; logic [8:0] y; logic [15:0] c;} pix_t;
  pix_t pq[$];
  logic [7:0] cq[$];

  tft_spi_sink dut (
    .clk(clk), .rst(rst), .tft_clk(tft_clk), .tft_mosi(tft_mosi), .tft_dc(tft_dc),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) pq.push_back('{pixel_x, pixel_y, pixel_color});
    if (cmd_valid) cq.push_back(cmd_code);
    if (frame_error) fe_cnt++;
  end

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 0; i < n; i++) begin
      tft_dc = dc;
      tft_mosi = b[7-i];
      tft_clk = 0;
      #40;
      tft_clk = 1;
      #40;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    tft_clk = 0;
    #3 rst = 1;
    repeat (4) @(posedge clk);
    #2 rst = 0;
    settle();
    pq.delete();
    cq.delete();
    fe_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_valid, byte_data, byte_dc, cmd_valid, cmd_code} !== 19'd0) begin
      errors++;
      $display("FAIL reset_byte: got %h want 0", {byte_valid, byte_data, byte_dc, cmd_valid, cmd_code});
    end
    checks++;
    if ({pixel_valid, pixel_x, pixel_y, pixel_color, frame_error} !== 36'd0) begin
      errors++;
      $display("FAIL reset_pixel: got %h want 0", {pixel_valid, pixel_x, pixel_y, pixel_color, frame_error});
    end
  endtask

  task automatic test_window_pixels();
    logic [7:0] d[8];
    d = '{8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h06};
    send_byte(8'h2A, 0);
    for (int i = 0; i < 4; i++) send_byte(d[i], 1);
    send_byte(8'h2B, 0);
    for (int i = 4; i < 8; i++) send_byte(d[i], 1);
    send_byte(8'h2C, 0);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hA0 + 8'(i), 1);
      send_byte(8'h50 + 8'(i), 1);
    end
    settle();
    checks++;
    if (cq.size() != 3 || cq[0] !== 8'h2A || cq[1] !== 8'h2B || cq[2] !== 8'h2C) begin
      errors++;
      $display("FAIL win_cmds: got %0d cmds want 2A,2B,2C", cq.size());
    end
    checks++;
    if (pq.size() != 6) begin
      errors++;
      $display("FAIL win_count: got %0d want 6", pq.size());
    end
    for (int i = 0; i < 6 && i < pq.size(); i++) begin
      checks++;
      if (pq[i].x !== 9'(10 + i % 3) || pq[i].y !== 9'(5 + i / 3) || pq[i].c !== {8'hA0 + 8'(i), 8'h50 + 8'(i)}) begin
        errors++;
        $display("FAIL win_pix%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, pq[i].x, pq[i].y, pq[i].c,
                 10 + i % 3, 5 + i / 3, {8'hA0 + 8'(i), 8'h50 + 8'(i)});
      end
    end
    pq.delete();
    cq.delete();
  endtask

  task automatic test_wrap();
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    settle();
    checks++;
    if (pq.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 2", pq.size());
    end else begin
      checks++;
      if (pq[0].x !== 9'd10 || pq[0].y !== 9'd5 || pq[0].c !== 16'h1122) begin
        errors++;
        $display("FAIL wrap_pix0: got (%0d,%0d,%h) want (10,5,1122)", pq[0].x, pq[0].y, pq[0].c);
      end
      checks++;
      if (pq[1].x !== 9'd11 || pq[1].y !== 9'd5 || pq[1].c !== 16'h3344) begin
        errors++;
        $display("FAIL wrap_pix1: got (%0d,%0d,%h) want (11,5,3344)", pq[1].x, pq[1].y, pq[1].c);
      end
    end
    pq.delete();
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits(8'hFF, 5, 1);
    repeat (100) @(posedge clk);
    checks++;
    if (fe_cnt != 1) begin
      errors++;
      $display("FAIL timeout_fe: got %0d pulses want 1", fe_cnt);
    end
    send_byte(8'h2C, 0);
    settle();
    checks++;
    if (cq.size() != 1 || cq[0] !== 8'h2C || byte_data !== 8'h2C) begin
      errors++;
      $display("FAIL timeout_cmd: got %0d cmds byte %h want one 2C", cq.size(), byte_data);
    end
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 1);
    settle();
    checks++;
    if (pq.size() != 1 || pq[0].x !== 9'd0 || pq[0].y !== 9'd0 || pq[0].c !== 16'hBEEF) begin
      errors++;
      $display("FAIL timeout_pix: got %0d pixels want one (0,0,beef)", pq.size());
    end
    checks++;
    if (fe_cnt != 1) begin
      errors++;
      $display("FAIL timeout_fe_once: got %0d pulses want 1", fe_cnt);
    end
    pq.delete();
    cq.delete();
  endtask

  task automatic test_partial_caset();
    do_reset();
    send_byte(8'h2A, 0);
    send_byte(8'h00, 1);
    send_byte(8'h05, 1);
    send_byte(8'h2C, 0);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    settle();
    checks++;
    if (pq.size() != 2) begin
      errors++;
      $display("FAIL partial_count: got %0d want 2", pq.size());
    end else begin
      checks++;
      if (pq[0].x !== 9'd0 || pq[0].y !== 9'd0 || pq[0].c !== 16'h1234) begin
        errors++;
        $display("FAIL partial_pix0: got (%0d,%0d,%h) want (0,0,1234)", pq[0].x, pq[0].y, pq[0].c);
      end
      checks++;
      if (pq[1].x !== 9'd1 || pq[1].y !== 9'd0 || pq[1].c !== 16'h5678) begin
        errors++;
        $display("FAIL partial_pix1: got (%0d,%0d,%h) want (1,0,5678)", pq[1].x, pq[1].y, pq[1].c);
      end
    end
    pq.delete();
    cq.delete();
  endtask

  task automatic test_abort_pixel();
    send_byte(8'h2C, 0);
    send_byte(8'hF8, 1);
    send_byte(8'h00, 0);
    settle();
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL abort_pix: got %0d pixels want 0", pq.size());
    end
    checks++;
    if (cq.size() != 2 || cq[1] !== 8'h00 || cmd_code !== 8'h00) begin
      errors++;
      $display("FAIL abort_cmd: got %0d cmds code %h want 2, 00", cq.size(), cmd_code);
    end
    pq.delete();
    cq.delete();
  endtask

  task automatic test_reset_mid_byte();
    send_byte(8'h2B, 0);
    settle();
    send_bits(8'hA5, 4, 1);
    #13 rst = 1;
    #1;
    checks++;
    if ({byte_valid, byte_data, byte_dc, cmd_valid, cmd_code, pixel_valid, pixel_x, pixel_y, pixel_color, frame_error} !== 55'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {byte_valid, byte_data, byte_dc, cmd_valid, cmd_code, pixel_valid, pixel_x, pixel_y, pixel_color, frame_error});
    end
    tft_clk = 0;
    repeat (4) @(posedge clk);
    #2 rst = 0;
    settle();
    fe_cnt = 0;
    cq.delete();
    send_byte(8'h2A, 0);
    settle();
    checks++;
    if (byte_data !== 8'h2A || byte_dc !== 1'b0 || cq.size() != 1 || cmd_code !== 8'h2A) begin
      errors++;
      $display("FAIL rst_mid_next: got byte %h dc %b cmds %0d want 2A,0,1", byte_data, byte_dc, cq.size());
    end
    checks++;
    if (fe_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_fe: got %0d want 0", fe_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_window_pixels();
    test_wrap();
    test_timeout();
    test_partial_caset();
    test_abort_pixel();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
